// File: rtl/uart_reg_responder.sv
// Byte-protocol register responder behind a UART: 'W',addr,data writes; 'R',addr reads.
// One reply byte per command, held on tx_data for TX_HOLD_CYCLES; half-duplex, no rx accepted while replying.
module uart_reg_responder #(
    parameter int NUM_REGS       = 8,
    parameter int TX_HOLD_CYCLES = 1100,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_flag,
    input  logic [7:0]            rx_data,
    input  logic                  parity_error,
    output logic                  rx_flag_clr,
    output logic [7:0]            tx_data,
    output logic                  tx_send,
    output logic                  reg_wr_en,
    output logic [7:0]            reg_wr_addr,
    output logic [7:0]            reg_wr_data,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    localparam int HW = $clog2(TX_HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(TX_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, SEND, WAIT_TX} state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            is_write;
    logic [7:0]      addr_q;
    logic            addr_ok_q;

    logic            listening;
    logic            accept;
    logic            rx_addr_ok;
    logic            tmo_hit;
    logic [7:0]      rd_byte;

    always_comb begin
        listening  = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
        // rx_flag is still high the cycle after a consume; the clr guard prevents a double take
        accept     = listening && rx_flag && !rx_flag_clr;
        rx_addr_ok = ({1'b0, rx_data} < 9'(NUM_REGS));
        tmo_hit    = (tmo_cnt >= TMO_MAX);
        rd_byte    = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rx_data == 8'(i)) rd_byte = regs_flat[i*8 +: 8];
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
            is_write    <= 1'b0;
            addr_q      <= 8'h00;
            addr_ok_q   <= 1'b0;
            rx_flag_clr <= 1'b0;
            tx_data     <= 8'h00;
            tx_send     <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 8'h00;
            reg_wr_data <= 8'h00;
            err_timeout <= 1'b0;
            regs_flat   <= '0;
        end else begin
            rx_flag_clr <= accept;
            tx_send     <= 1'b0;
            reg_wr_en   <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (parity_error || !(rx_data == CMD_W || rx_data == CMD_R)) begin
                            tx_data <= NAK;
                            tx_send <= 1'b1;
                            state   <= SEND;
                        end else begin
                            is_write <= (rx_data == CMD_W);
                            tmo_cnt  <= '0;
                            state    <= GET_ADDR;
                        end
                    end
                end

                GET_ADDR: begin
                    if (accept) begin
                        tmo_cnt <= '0;
                        if (parity_error) begin
                            tx_data <= NAK;
                            tx_send <= 1'b1;
                            state   <= SEND;
                        end else if (is_write) begin
                            addr_q    <= rx_data;
                            addr_ok_q <= rx_addr_ok;
                            state     <= GET_DATA;
                        end else begin
                            addr_q    <= rx_data;
                            addr_ok_q <= rx_addr_ok;
                            tx_data   <= rx_addr_ok ? rd_byte : NAK;
                            tx_send   <= 1'b1;
                            state     <= SEND;
                        end
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                GET_DATA: begin
                    if (accept) begin
                        tmo_cnt <= '0;
                        tx_send <= 1'b1;
                        state   <= SEND;
                        if (!parity_error && addr_ok_q) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr_q == 8'(i)) regs_flat[i*8 +: 8] <= rx_data;
                            end
                            reg_wr_en   <= 1'b1;
                            reg_wr_addr <= addr_q;
                            reg_wr_data <= rx_data;
                            tx_data     <= ACK;
                        end else begin
                            tx_data <= NAK;
                        end
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                SEND: begin
                    hold_cnt <= '0;
                    state    <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (hold_cnt >= HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Byte-level command responder on the host side of the UART core. Consumes received bytes through the UART's rx_flag/rx_data/rx_flag_clr handshake and parses a 2- or 3-byte read/write protocol against an internal 8-bit register file. Returns one reply byte per command through the UART's tx_data/tx_send input. It is the responder end of the serial link, sitting between the UART core and register-mapped control logic.

## Interface
Parameters:
- NUM_REGS, 8 — register count, 1..256; valid addresses 0..NUM_REGS-1.
- TX_HOLD_CYCLES, 1100 — cycles tx_data is held after tx_send before the next action; must be ≥ one full UART frame plus one bit time.
- TIMEOUT_CYCLES, 100000 — maximum idle gap between bytes of one command.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  system clock, shared with the UART core.
- rst  input  1  synchronous, active-high reset.
- rx_flag  input  1  sticky byte-available flag from the UART.
- rx_data  input  8  received byte; valid while rx_flag=1.
- parity_error  input  1  parity status of the current rx byte.
- rx_flag_clr  output  1  one-cycle pulse that consumes the current byte.
- tx_data  output  8  reply byte; held stable for the whole hold window.
- tx_send  output  1  one-cycle transmit request.
- reg_wr_en  output  1  one-cycle pulse on a committed register write.
- reg_wr_addr  output  8  write address; valid with reg_wr_en.
- reg_wr_data  output  8  write data; valid with reg_wr_en.
- regs_flat  output  NUM_REGS*8  register file; reg i is at [8i+7:8i].
- busy  output  1  high in any state except IDLE.
- err_timeout  output  1  one-cycle pulse when a partial command is abandoned.

## Operation
- Byte acceptance: a byte is accepted when rx_flag=1 and rx_flag_clr=0. rx_flag_clr is registered and pulses in the cycle after acceptance.
- Protocol: 0x57 'W', addr, data writes a register and replies 0x06 (ACK). 0x52 'R', addr replies with the register contents. Any other command byte replies 0x15 (NAK).
- Address error: addr ≥ NUM_REGS replies NAK. For a write, the data byte is still consumed and no write occurs.
- Parity error: a parity_error=1 on any accepted byte aborts the command immediately and replies NAK. No write occurs.
- States:
  - IDLE: on accept, go to GET_ADDR if the byte is 'W' or 'R'; otherwise load NAK and go to SEND.
  - GET_ADDR: on accept, latch addr. 'R' loads reply = reg[addr] (or NAK) and goes to SEND. 'W' goes to GET_DATA.
  - GET_DATA: on accept, write if addr is valid, load ACK or NAK, go to SEND.
  - SEND: drive tx_send=1 for exactly one cycle, then go to WAIT_TX.
  - WAIT_TX: count TX_HOLD_CYCLES, then go to IDLE.
- Timeout: in GET_ADDR or GET_DATA, the timeout counter resets on each accept. When it reaches TIMEOUT_CYCLES, pulse err_timeout and return to IDLE with no reply.
- Half-duplex: no bytes are accepted in SEND or WAIT_TX. A byte arriving then stays pending in rx_flag and is accepted on return to IDLE.
- Write commit: the register file is written in the accept cycle of the data byte. reg_wr_en/addr/data are registered and appear one cycle later.
- Reset values: all registers 0x00; tx_data 0x00; tx_send, rx_flag_clr, reg_wr_en, busy, err_timeout all 0; reg_wr_addr and reg_wr_data 0x00; state IDLE; counters 0.
- Reset mid-operation: abandons any command without a reply. A pending rx_flag is not cleared by reset and is accepted after reset deasserts.

## Timing
- Accept at cycle t: rx_flag_clr=1 at t+1, and rx_flag drops at t+2. The acceptance guard prevents a double consume at t+1.
- Last byte accepted at t: SEND at t+1, tx_send=1 at t+1.
  - tx_data is valid from t+1 and is held unchanged until WAIT_TX exits.
  - WAIT_TX spans t+2 .. t+1+TX_HOLD_CYCLES; IDLE follows.
- Read data: sampled in the addr accept cycle. A write committed in the same cycle is not visible to that read (writes and reads never coincide by protocol).
- Counters: hold counter width $clog2(TX_HOLD_CYCLES+1); timeout counter width $clog2(TIMEOUT_CYCLES+1). Both saturate and never wrap.

## Test plan
- Write then read: 0x57,0x03,0xA5 → reg_wr_en with addr 3 / data 0xA5, reply 0x06, regs_flat[31:24]=0xA5. Then 0x52,0x03 → reply 0xA5.
- Bad address: with NUM_REGS=8, 0x57,0x08,0x11 → reply 0x15, no reg_wr_en, all regs unchanged. Then 0x52,0xFF → reply 0x15.
- Unknown command: 0x41 → reply 0x15 in the cycle after acceptance. busy returns to 0 after TX_HOLD_CYCLES.
- Parity error on the addr byte of 'W' → immediate NAK, no write. The next byte is parsed as a new command.
- Timeout: 0x57 followed by silence for TIMEOUT_CYCLES → err_timeout pulse, no tx_send, back in IDLE.
- Back-to-back and reset:
  - A byte arriving during WAIT_TX is accepted exactly once after the hold window.
  - rst asserted in GET_DATA → all outputs at reset values, no reply.
